// File: rtl/logic_analyzer_pretrig_pkg.sv
// Shared definitions for the logic-analyzer pre-trigger capture engine.
// The state encoding is what the bus slave exposes in its status register
// through cap_state. Keep the numeric values stable.
package logic_analyzer_pretrig_pkg;

    typedef enum logic [2:0] {
        LA_IDLE  = 3'd0,
        LA_PRE   = 3'd1,
        LA_WAIT  = 3'd2,
        LA_POST  = 3'd3,
        LA_READY = 3'd4,
        LA_DONE  = 3'd5
    } la_state_e;

endpackage

// File: rtl/logic_analyzer_pretrig_bram.sv
// Simple dual-port sample buffer for the capture engine.
//   clk      : single clock for both ports
//   we       : port A write enable
//   wr_addr  : port A write address
//   wr_data  : port A write data
//   rd_addr  : port B read address, sampled every cycle
//   rd_data  : port B registered read data (one cycle latency)
// The contents are not reset. Captured data is only meaningful once a run has completed.
module logic_analyzer_pretrig_bram #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/logic_analyzer_pretrig.sv
// Logic-analyzer capture engine with a wrap-safe pre-trigger window.
// Samples cap_data on a divided tick into a circular buffer. It waits for a level/edge
// trigger, or for the external trigger, and skips repeat_count events first. After
// the trigger it fills the rest of the buffer. The buffer is then read oldest-first.
//   clk, rst                    : clock, synchronous active-high reset
//   cap_data, cap_external_trigger : sampled inputs / external trigger level
//   clk_div                     : tick every clk_div+1 cycles
//   trigger, trigger_mask, trigger_edge : per-bit trigger value / participation / edge mode
//   pre_trigger, repeat_count   : samples kept before trigger / events to skip
//   enable, restart             : arm-run (low aborts) / leave DONE and re-arm
//   finished, triggered, cap_state : status
//   data_out_read_strobe, data_out_read_size, data_out : read-out interface
module logic_analyzer_pretrig
    import logic_analyzer_pretrig_pkg::*;
#(
    parameter int CAPTURE_WIDTH = 32,
    parameter int CAPTURE_DEPTH = 10
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [CAPTURE_WIDTH-1:0] cap_data,
    input  logic                     cap_external_trigger,
    input  logic [31:0]              clk_div,
    input  logic [CAPTURE_WIDTH-1:0] trigger,
    input  logic [CAPTURE_WIDTH-1:0] trigger_mask,
    input  logic [CAPTURE_WIDTH-1:0] trigger_edge,
    input  logic [CAPTURE_DEPTH-1:0] pre_trigger,
    input  logic [31:0]              repeat_count,
    input  logic                     enable,
    input  logic                     restart,
    output logic                     finished,
    output logic                     triggered,
    output logic [2:0]               cap_state,
    input  logic                     data_out_read_strobe,
    output logic [31:0]              data_out_read_size,
    output logic [CAPTURE_WIDTH-1:0] data_out
);

    localparam int CW = CAPTURE_WIDTH;
    localparam int CD = CAPTURE_DEPTH;
    localparam int unsigned N = 1 << CD;
    localparam logic [CD-1:0] ONE_CD = {{(CD-1){1'b0}}, 1'b1};

    // Level bits must equal the trigger value. Edge bits must have just
    // changed into the trigger value (current == trigger, previous != trigger).
    function automatic logic trig_hit(input logic [CW-1:0] d, input logic [CW-1:0] prev,
                                      input logic [CW-1:0] trig, input logic [CW-1:0] mask,
                                      input logic [CW-1:0] edge_m);
        logic [CW-1:0] level_bad;
        logic [CW-1:0] edge_bad;
        level_bad = (d ^ trig) & mask & ~edge_m;
        edge_bad  = (mask & edge_m) & ((d ^ trig) | ~(d ^ prev));
        return (level_bad == '0) && (edge_bad == '0);
    endfunction

    la_state_e       state_q, state_d;
    logic [31:0]     div_cnt_q, div_cnt_d;
    logic [31:0]     cfg_div_q, cfg_div_d;
    logic [CW-1:0]   cfg_trig_q, cfg_trig_d;
    logic [CW-1:0]   cfg_mask_q, cfg_mask_d;
    logic [CW-1:0]   cfg_edge_q, cfg_edge_d;
    logic [CD-1:0]   cfg_pre_q, cfg_pre_d;
    logic [31:0]     rep_q, rep_d;
    logic [CD-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CD-1:0]   fill_q, fill_d;
    logic [CD-1:0]   post_q, post_d;
    logic [CD-1:0]   start_q, start_d;
    logic [CD-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   prev_q, prev_d;
    logic            triggered_q, triggered_d;

    logic            capturing;
    logic            tick;
    logic            event_hit;
    logic            wr_en;
    logic [CD-1:0]   rd_addr;
    logic [CW-1:0]   rd_data;

    assign capturing = (state_q == LA_PRE) || (state_q == LA_WAIT) || (state_q == LA_POST);
    assign tick      = capturing && ((cfg_div_q == '0) || (div_cnt_q == cfg_div_q));
    assign event_hit = trig_hit(cap_data, prev_q, cfg_trig_q, cfg_mask_q, cfg_edge_q)
                       || cap_external_trigger;

    always_comb begin
        state_d     = state_q;
        div_cnt_d   = '0;
        cfg_div_d   = cfg_div_q;
        cfg_trig_d  = cfg_trig_q;
        cfg_mask_d  = cfg_mask_q;
        cfg_edge_d  = cfg_edge_q;
        cfg_pre_d   = cfg_pre_q;
        rep_d       = rep_q;
        wr_ptr_d    = wr_ptr_q;
        fill_d      = fill_q;
        post_d      = post_q;
        start_d     = start_q;
        rd_ptr_d    = rd_ptr_q;
        prev_d      = prev_q;
        triggered_d = triggered_q;
        wr_en       = 1'b0;
        rd_addr     = rd_ptr_q;

        if (capturing) begin
            div_cnt_d = tick ? '0 : div_cnt_q + 32'd1;
        end
        if (tick) begin
            wr_en    = 1'b1;
            wr_ptr_d = wr_ptr_q + ONE_CD;
            prev_d   = cap_data;
        end

        case (state_q)
            LA_IDLE: begin
                if (enable) begin
                    cfg_div_d   = clk_div;
                    cfg_trig_d  = trigger;
                    cfg_mask_d  = trigger_mask;
                    cfg_edge_d  = trigger_edge;
                    cfg_pre_d   = pre_trigger;
                    rep_d       = repeat_count;
                    wr_ptr_d    = '0;
                    fill_d      = '0;
                    prev_d      = cap_data;
                    triggered_d = 1'b0;
                    state_d     = (pre_trigger == '0) ? LA_WAIT : LA_PRE;
                end
            end
            LA_PRE: begin
                if (tick) begin
                    fill_d = fill_q + ONE_CD;
                    if ((fill_q + ONE_CD) == cfg_pre_q) begin
                        state_d = LA_WAIT;
                    end
                end
            end
            LA_WAIT: begin
                if (tick && event_hit) begin
                    if (rep_q != '0) begin
                        rep_d = rep_q - 32'd1;
                    end else begin
                        // The trigger sample is written at wr_ptr_q this tick,
                        // so the window starts pre samples earlier (mod N).
                        start_d     = wr_ptr_q - cfg_pre_q;
                        post_d      = {CD{1'b1}} - cfg_pre_q;
                        triggered_d = 1'b1;
                        // A full pre-trigger window leaves nothing to capture afterwards.
                        state_d     = (cfg_pre_q == {CD{1'b1}}) ? LA_READY : LA_POST;
                    end
                end
            end
            LA_POST: begin
                if (tick) begin
                    post_d = post_q - ONE_CD;
                    if (post_q == ONE_CD) begin
                        state_d = LA_READY;
                    end
                end
            end
            LA_READY: begin
                rd_ptr_d = start_q;
                rd_addr  = start_q;
                state_d  = LA_DONE;
            end
            LA_DONE: begin
                if (restart) begin
                    state_d     = LA_IDLE;
                    triggered_d = 1'b0;
                end else if (data_out_read_strobe) begin
                    rd_ptr_d = rd_ptr_q + ONE_CD;
                    rd_addr  = rd_ptr_q + ONE_CD;
                end
            end
            default: state_d = LA_IDLE;
        endcase

        if (!enable) begin
            state_d     = LA_IDLE;
            triggered_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= LA_IDLE;
            div_cnt_q   <= '0;
            cfg_div_q   <= '0;
            cfg_trig_q  <= '0;
            cfg_mask_q  <= '0;
            cfg_edge_q  <= '0;
            cfg_pre_q   <= '0;
            rep_q       <= '0;
            wr_ptr_q    <= '0;
            fill_q      <= '0;
            post_q      <= '0;
            start_q     <= '0;
            rd_ptr_q    <= '0;
            prev_q      <= '0;
            triggered_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_cnt_q   <= div_cnt_d;
            cfg_div_q   <= cfg_div_d;
            cfg_trig_q  <= cfg_trig_d;
            cfg_mask_q  <= cfg_mask_d;
            cfg_edge_q  <= cfg_edge_d;
            cfg_pre_q   <= cfg_pre_d;
            rep_q       <= rep_d;
            wr_ptr_q    <= wr_ptr_d;
            fill_q      <= fill_d;
            post_q      <= post_d;
            start_q     <= start_d;
            rd_ptr_q    <= rd_ptr_d;
            prev_q      <= prev_d;
            triggered_q <= triggered_d;
        end
    end

    logic_analyzer_pretrig_bram #(
        .DATA_WIDTH (CW),
        .ADDR_WIDTH (CD)
    ) u_bram (
        .clk     (clk),
        .we      (wr_en),
        .wr_addr (wr_ptr_q),
        .wr_data (cap_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    // The raw buffer output is only presented once a capture is complete. This keeps
    // data_out at zero out of reset and while a run is in progress.
    assign data_out           = (state_q == LA_DONE) ? rd_data : '0;
    assign finished           = (state_q == LA_DONE);
    assign triggered          = triggered_q;
    assign cap_state          = state_q;
    assign data_out_read_size = 32'(N);

endmodule
